// File: rtl/data_mem_controller.sv
// MEM-stage data memory responder: B/H/W loads with sign/zero extension, lane-merged stores,
// fixed-latency IDLE/ACCESS/DONE handshake. Optional macro MISALIGN_TRAP_EN flags misaligned H/W accesses.
module data_mem_controller #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MEM_READ,
   input  logic        MEM_WRITE,
   input  logic [2:0]  FUNC3,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] READ_DATA,
   output logic        BUSYWAIT,
   output logic        MISALIGNED
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state;
   logic          is_write;
   logic [2:0]    f3_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [CW-1:0] cnt;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic [31:0]   old_word, new_word, load_val;
   logic [7:0]    bsel;
   logic [15:0]   hsel;
   logic          size_ok, misal, access_now;
   logic          unused_addr;

   // Addresses wrap modulo the array size; the high bits are deliberately dropped.
   assign unused_addr = ^ADDRESS[31:AW+2];

   assign access_now = (state == ACCESS) && (cnt == '0);
   assign BUSYWAIT   = !RESET && ((state == ACCESS) || ((state == IDLE) && (MEM_READ || MEM_WRITE)));

   always_comb begin
      widx     = addr_q[AW+1:2];
      lane     = addr_q[1:0];
      old_word = mem[widx];
      bsel     = old_word[{lane, 3'b000} +: 8];
      hsel     = lane[1] ? old_word[31:16] : old_word[15:0];
      new_word = old_word;
      load_val = '0;
      size_ok  = 1'b0;
      misal    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      case (f3_q)
         3'b001, 3'b101: misal = lane[0];
         3'b010:         misal = |lane;
         default:        misal = 1'b0;
      endcase
`endif
      // Without the trap, ignoring the low address bits of H/W is what forces alignment.
      case (f3_q)
         3'b000: begin
            size_ok = 1'b1;
            new_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
            load_val = {{24{bsel[7]}}, bsel};
         end
         3'b001: begin
            size_ok = 1'b1;
            if (lane[1]) new_word[31:16] = wdata_q[15:0];
            else         new_word[15:0]  = wdata_q[15:0];
            load_val = {{16{hsel[15]}}, hsel};
         end
         3'b010: begin
            size_ok  = 1'b1;
            new_word = wdata_q;
            load_val = old_word;
         end
         3'b100:  load_val = {24'h0, bsel};
         3'b101:  load_val = {16'h0, hsel};
         default: load_val = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (access_now && is_write && size_ok && !misal)
         mem[widx] <= new_word;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         READ_DATA <= '0;
         is_write  <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MEM_READ || MEM_WRITE) begin
                  is_write <= MEM_WRITE;
                  f3_q     <= FUNC3;
                  addr_q   <= ADDRESS[AW+1:0];
                  wdata_q  <= WRITE_DATA;
                  cnt      <= CW'(LATENCY - 1);
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (!is_write && !misal) READ_DATA <= load_val;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) MISALIGNED <= 1'b0;
      else       MISALIGNED <= access_now && misal;
   end
`else
   assign MISALIGNED = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// Scoreboard bench for data_mem_controller: driver queues hand-computed results, monitor checks on DONE.
module tb_data_mem_controller;

   localparam int unsigned LAT = 3;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        MEM_READ, MEM_WRITE;
   logic [2:0]  FUNC3;
   logic [31:0] ADDRESS, WRITE_DATA;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT, MISALIGNED;

   data_mem_controller #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
      .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
      .FUNC3(FUNC3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
      .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        mis;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   int unsigned busy_cnt = 0;
   logic [31:0] exp_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Completion is the 1->0 edge of BUSYWAIT, i.e. the DONE cycle.
   always @(negedge CLK) begin
      if (!mon_en) begin
         busy_cnt = 0;
      end else if (BUSYWAIT) begin
         busy_cnt++;
      end else if (busy_cnt > 0) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got completion expected none");
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_rd"}, READ_DATA, e.rd);
            chk({e.name, "_mis"}, {31'h0, MISALIGNED}, {31'h0, e.mis});
            chk({e.name, "_stall"}, busy_cnt, LAT + 1);
         end
         busy_cnt = 0;
      end
   end

   // Holds the request for n back-to-back transactions, then drops it in the last DONE cycle.
   task automatic req(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic mis, input int unsigned n);
      int unsigned done_cnt = 0;
      int unsigned cyc = 0;
      for (int unsigned i = 0; i < n; i++) sbq.push_back('{name, exp_rd, mis});
      MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDRESS = a; WRITE_DATA = wd;
      while (done_cnt < n && cyc < 50) begin
         @(posedge CLK); #1;
         cyc++;
         if (!BUSYWAIT) done_cnt++;
      end
      if (done_cnt < n) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d completions expected %0d", name, done_cnt, n);
      end
      MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
      FUNC3 = 3'b010; ADDRESS = '0; WRITE_DATA = '0;
      #12;
      chk("reset_rd", READ_DATA, 32'h0);
      chk("reset_busy", {31'h0, BUSYWAIT}, 32'h0);
      chk("reset_mis", {31'h0, MISALIGNED}, 32'h0);
      RESET = 1'b0;
      @(posedge CLK); #1;
      mon_en = 1'b1;

      req("sw10", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1);
      exp_rd = 32'hDEADBEEF;
      req("lw10_b2b", 1, 0, 3'b010, 32'h10, 32'h0, 0, 2);

      req("sw20", 0, 1, 3'b010, 32'h20, 32'h80FF1234, 0, 1);
      exp_rd = 32'hFFFFFF80; req("lb23",  1, 0, 3'b000, 32'h23, 32'h0, 0, 1);
      exp_rd = 32'h00000080; req("lbu23", 1, 0, 3'b100, 32'h23, 32'h0, 0, 1);
      exp_rd = 32'hFFFF80FF; req("lh22",  1, 0, 3'b001, 32'h22, 32'h0, 0, 1);
      exp_rd = 32'h00001234; req("lhu20", 1, 0, 3'b101, 32'h20, 32'h0, 0, 1);

      req("sw30", 0, 1, 3'b010, 32'h30, 32'h11223344, 0, 1);
      req("sb31", 0, 1, 3'b000, 32'h31, 32'h123456AA, 0, 1);
      req("sh32", 0, 1, 3'b001, 32'h32, 32'h7777BEEF, 0, 1);
      exp_rd = 32'hBEEFAA44; req("lw30", 1, 0, 3'b010, 32'h30, 32'h0, 0, 1);

      req("sw40", 0, 1, 3'b010, 32'h40, 32'h01020304, 0, 1);
      mon_en = 1'b0;
      MEM_WRITE = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h40; WRITE_DATA = 32'hCAFEF00D;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RESET = 1'b1;
      #1;
      chk("rst_mid_busy", {31'h0, BUSYWAIT}, 32'h0);
      chk("rst_mid_rd", READ_DATA, 32'h0);
      MEM_WRITE = 1'b0;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(posedge CLK); #1;
      mon_en = 1'b1;
      exp_rd = 32'h0;
      chk("post_rst_rd", READ_DATA, exp_rd);
      exp_rd = 32'h01020304; req("lw40_after_rst", 1, 0, 3'b010, 32'h40, 32'h0, 0, 1);

      req("sw404", 0, 1, 3'b010, 32'h404, 32'h55AA55AA, 0, 1);
      exp_rd = 32'h55AA55AA; req("lw004_wrap", 1, 0, 3'b010, 32'h004, 32'h0, 0, 1);

      if (!TRAP) exp_rd = 32'hDEADBEEF;
      req("lw13_misal", 1, 0, 3'b010, 32'h13, 32'h0, TRAP, 1);
      if (!TRAP) exp_rd = 32'h00001234;
      req("lhu21_misal", 1, 0, 3'b101, 32'h21, 32'h0, TRAP, 1);

      req("rdwr50", 1, 1, 3'b010, 32'h50, 32'h13579BDF, 0, 1);
      req("sbad50", 0, 1, 3'b110, 32'h50, 32'hFFFFFFFF, 0, 1);
      exp_rd = 32'h13579BDF; req("lw50", 1, 0, 3'b010, 32'h50, 32'h0, 0, 1);
      exp_rd = 32'h0; req("lbad10", 1, 0, 3'b011, 32'h10, 32'h0, 0, 1);

      repeat (3) @(posedge CLK);
      chk("sb_drained", sbq.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
